// File: rtl/traffic_light_supervisor_if.sv
// Lamp-supervisor signal bundle: operator request, normal-mode sub-SM lights in,
// road lamp drive and status out.
interface traffic_light_supervisor_if;
  logic       maintenance_req;
  logic [2:0] primary_ryb_norm;
  logic [2:0] secondary_ryb_norm;
  logic       normal_mode_ssm_idle;
  logic [2:0] primary_road_light_ryb;
  logic [2:0] secondary_road_light_ryb;
  logic [1:0] mode;
  logic       fault_latched;

  modport master (
    output maintenance_req, primary_ryb_norm, secondary_ryb_norm,
    input  normal_mode_ssm_idle, primary_road_light_ryb, secondary_road_light_ryb,
           mode, fault_latched
  );

  modport slave (
    input  maintenance_req, primary_ryb_norm, secondary_ryb_norm,
    output normal_mode_ssm_idle, primary_road_light_ryb, secondary_road_light_ryb,
           mode, fault_latched
  );
endinterface

// File: rtl/traffic_light_supervisor.sv
// Supervisory lamp controller: power-up all-red, normal pass-through, maintenance
// clearance/flash and a sticky conflict-fault flash. All lamp outputs are registered.
module traffic_light_supervisor #(
  parameter int STATE_TIMER_BITS        = 26,
  parameter int ALL_RED_COUNT           = 20_000_000,
  parameter int CLEARANCE_COUNT         = 30_000_000,
  parameter int FLASH_HALF_PERIOD_COUNT = 5_000_000
) (
  input  logic                        clk,
  input  logic                        reset_n,
  traffic_light_supervisor_if.slave   bus
);

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;
  localparam logic [2:0] OFF    = 3'b000;

  typedef logic [STATE_TIMER_BITS-1:0] timer_t;
  localparam timer_t ALL_RED_LOAD = timer_t'(ALL_RED_COUNT);
  localparam timer_t CLEAR_LOAD   = timer_t'(CLEARANCE_COUNT);
  localparam timer_t FLASH_LOAD   = timer_t'(FLASH_HALF_PERIOD_COUNT);

  typedef enum logic [2:0] {
    S_ALL_RED   = 3'd0,
    S_NORMAL    = 3'd1,
    S_CLEARANCE = 3'd2,
    S_FLASH     = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  state_t           state_reg, state_next;
  timer_t           timer_reg, timer_next;
  logic             flash_phase_reg, flash_phase_next;
  logic             fault_reg, fault_next;
  logic             maint_meta_reg, maint_s_reg;
  logic             idle_reg, idle_next;
  logic [1:0]       mode_reg, mode_next;
  // Index 0 is the primary road, index 1 the secondary road.
  logic [1:0][2:0]  lamp_reg, lamp_next;
  logic [1:0][2:0]  road_in, road_clear;
  logic [1:0]       road_bad, road_active;
  logic             conflict, timer_zero;

  assign road_in = {bus.secondary_ryb_norm, bus.primary_ryb_norm};

  for (genvar gi = 0; gi < 2; gi++) begin : g_road
    assign road_bad[gi]    = !(road_in[gi] == RED || road_in[gi] == YELLOW || road_in[gi] == GREEN);
    assign road_active[gi] = road_in[gi] != RED;
    assign road_clear[gi]  = (lamp_reg[gi] == GREEN || lamp_reg[gi] == YELLOW) ? YELLOW : RED;
  end

  assign conflict   = (|road_bad) || (&road_active);
  assign timer_zero = (timer_reg == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      maint_meta_reg  <= 1'b0;
      maint_s_reg     <= 1'b0;
      state_reg       <= S_ALL_RED;
      timer_reg       <= ALL_RED_LOAD;
      flash_phase_reg <= 1'b1;
      fault_reg       <= 1'b0;
      idle_reg        <= 1'b1;
      mode_reg        <= 2'd0;
      lamp_reg        <= {RED, RED};
    end else begin
      maint_meta_reg  <= bus.maintenance_req;
      maint_s_reg     <= maint_meta_reg;
      state_reg       <= state_next;
      timer_reg       <= timer_next;
      flash_phase_reg <= flash_phase_next;
      fault_reg       <= fault_next;
      idle_reg        <= idle_next;
      mode_reg        <= mode_next;
      lamp_reg        <= lamp_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    timer_next       = timer_zero ? timer_reg : timer_reg - 1'b1;
    flash_phase_next = flash_phase_reg;
    fault_next       = fault_reg;
    case (state_reg)
      S_ALL_RED: begin
        if (timer_zero) begin
          if (maint_s_reg) begin
            state_next       = S_FLASH;
            flash_phase_next = 1'b1;
            timer_next       = FLASH_LOAD;
          end else begin
            state_next = S_NORMAL;
          end
        end
      end
      S_NORMAL: begin
        // A conflict outranks a maintenance request in the same cycle.
        if (conflict) begin
          state_next       = S_FAULT;
          fault_next       = 1'b1;
          flash_phase_next = 1'b1;
          timer_next       = FLASH_LOAD;
        end else if (maint_s_reg) begin
          if (lamp_reg[0] == RED && lamp_reg[1] == RED) begin
            state_next = S_ALL_RED;
            timer_next = ALL_RED_LOAD;
          end else begin
            state_next = S_CLEARANCE;
            timer_next = CLEAR_LOAD;
          end
        end
      end
      S_CLEARANCE: begin
        if (timer_zero) begin
          state_next = S_ALL_RED;
          timer_next = ALL_RED_LOAD;
        end
      end
      S_FLASH: begin
        if (!maint_s_reg) begin
          state_next = S_ALL_RED;
          timer_next = ALL_RED_LOAD;
        end else if (timer_zero) begin
          flash_phase_next = !flash_phase_reg;
          timer_next       = FLASH_LOAD;
        end
      end
      S_FAULT: begin
        if (timer_zero) begin
          flash_phase_next = !flash_phase_reg;
          timer_next       = FLASH_LOAD;
        end
      end
      default: begin
        state_next       = S_FAULT;
        fault_next       = 1'b1;
        flash_phase_next = 1'b1;
        timer_next       = FLASH_LOAD;
      end
    endcase
  end

  // Outputs are derived from the state being entered so they change on the same edge.
  always_comb begin
    lamp_next = lamp_reg;
    mode_next = 2'd3;
    idle_next = (state_next != S_NORMAL);
    case (state_next)
      S_ALL_RED: begin
        lamp_next = {RED, RED};
        mode_next = 2'd0;
      end
      S_NORMAL: begin
        lamp_next = road_in;
        mode_next = 2'd1;
      end
      S_CLEARANCE: begin
        if (state_reg == S_NORMAL) lamp_next = road_clear;
        mode_next = 2'd2;
      end
      S_FLASH: begin
        lamp_next = {flash_phase_next ? RED : OFF, flash_phase_next ? YELLOW : OFF};
        mode_next = 2'd2;
      end
      S_FAULT: begin
        lamp_next = {flash_phase_next ? RED : OFF, flash_phase_next ? RED : OFF};
        mode_next = 2'd3;
      end
      default: begin
        lamp_next = {RED, RED};
        mode_next = 2'd3;
      end
    endcase
  end

  assign bus.normal_mode_ssm_idle     = idle_reg;
  assign bus.primary_road_light_ryb   = lamp_reg[0];
  assign bus.secondary_road_light_ryb = lamp_reg[1];
  assign bus.mode                     = mode_reg;
  assign bus.fault_latched            = fault_reg;

endmodule
